dsp_share_arb: RTL and testbench
================================

Name: dsp_share_arb

Overview:
- Shares one dsp48a1_inst (flat 92-bit input bus, 48-bit output bus) between up to NUM_CLIENTS datapath blocks, e.g. gen_pulse left/right voice math plus filter engines.
- Round-robin arbitration with hold-while-requested tenure.
- Muxes the owner's dsp_ins_flat onto the shared DSP and broadcasts dsp_outs_flat to all clients.
- Optionally measures DSP busy cycles per 48 kHz sample period.

Parameters:
- NUM_CLIENTS, 4, number of requesters (1..8).
- DSP_IN_W, 92, width of the flat DSP input bus.
- DSP_OUT_W, 48, width of the flat DSP output bus.
- ID_W, 3, width of owner_id (must cover NUM_CLIENTS-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- client_req  in  NUM_CLIENTS  per-client DSP request, level.
- client_gnt  out  NUM_CLIENTS  one-hot grant, registered.
- client_dsp_ins_flat  in  NUM_CLIENTS*DSP_IN_W  concatenated client DSP inputs; client k occupies bits [k*DSP_IN_W +: DSP_IN_W].
- client_dsp_outs_flat  out  DSP_OUT_W  shared DSP output, broadcast to all clients.
- dsp_ins_flat  out  DSP_IN_W  to dsp48a1_inst.
- dsp_outs_flat  in  DSP_OUT_W  from dsp48a1_inst.
- owner_vld  out  1  a grant is active.
- owner_id  out  ID_W  index of the current owner; 0 when idle.
- sample_rate_trig  in  1  single-cycle 48 kHz strobe.
- util_cycles  out  16  busy cycles in the last completed sample period.
- util_peak  out  16  maximum util_cycles since reset.

Behaviour:
- Reset (async assert, sync release):
  - client_gnt=0, owner_vld=0, owner_id=0, rr_ptr=0.
  - util_cycles=0, util_peak=0, busy counter=0.
- State per clock edge: IDLE (owner_vld=0) or OWNED(k).
- OWNED(k):
  - If client_req[k]=1, remain OWNED(k). No preemption.
  - If client_req[k]=0, release at this edge and set rr_ptr=(k+1) mod NUM_CLIENTS.
  - In the same edge, grant the first requester at or after the new rr_ptr, searching circularly with k excluded (zero-idle handover). If none is requesting, go to IDLE.
- IDLE: if any request is high, grant the first requester circularly from rr_ptr.
- Latency: req rise to gnt rise = 1 clock. Owner req fall to gnt fall = 1 clock.
- client_gnt is always one-hot or zero, never multi-hot. Requests from non-owners are ignored until arbitration.
- Clients keep req high until their last DSP result (DSP pipeline latency included) has been captured from client_dsp_outs_flat. The arbiter does not track DSP latency.
- dsp_ins_flat is a combinational mux of the owner's slice, selected by the registered owner_id and owner_vld. When idle it is all zeros (opmode 0).
- client_dsp_outs_flat = dsp_outs_flat, pure wire with no added latency.
- A request that pulses for fewer than 1 clock, between edges, is not seen.
- NUM_CLIENTS=1: the grant follows req delayed by one clock.
- Reset asserted mid-tenure: grant drops immediately (async) and rr_ptr returns to 0.

Optional Feature:
- Macro DSP_ARB_UTIL_EN.
- Defined:
  - A 16-bit busy counter increments each cycle owner_vld=1, saturating at 0xFFFF.
  - On a sample_rate_trig cycle: util_cycles <= counter + owner_vld (saturated); counter <= 0; util_peak <= max(util_peak, that value).
  - This is the audit that each gen_pulse sample fits within CLK_DIV_48K cycles.
- Undefined: util_cycles and util_peak are tied to 0, sample_rate_trig is ignored, and no counter logic is synthesised. Ports remain present.

Test Plan:
- Reset, then req=4'b0001 at cycle 10 and held → gnt=4'b0001 at cycle 11, owner_id=0. dsp_ins_flat equals slice 0 and is all zeros before cycle 11.
- req=4'b1111 held, each owner drops its req for 1 cycle after 5 cycles of tenure → grants rotate 0,1,2,3,0 with no idle cycle between owners.
- Owner 2 active, req[1] rises → gnt stays 4'b0100 until req[2] falls. Next edge gnt=4'b0010, rr_ptr=3.
- Owner 2 active, req=4'b0100, req[2] falls → gnt=0 next edge, owner_vld=0, dsp_ins_flat=0. Then req[0] rises → gnt=4'b0001.
- Assert reset during tenure of client 3 → gnt=0 without a clock edge. After release with req=4'b1000, gnt=4'b1000 one clock later.
- DSP_ARB_UTIL_EN, CLK_DIV_48K=2000, client busy 300 cycles per period → util_cycles=300. A later period with 500 busy cycles → util_peak=500. Without the macro, both outputs read 0.

Source files
------------

// File: rtl/dsp_share_arb.sv
// Round-robin arbiter sharing one DSP48A1 between NUM_CLIENTS requesters, with hold-while-requested.
// Define DSP_ARB_UTIL_EN to enable per-sample-period DSP busy-cycle measurement.
module dsp_share_arb #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned DSP_IN_W    = 92,
  parameter int unsigned DSP_OUT_W   = 48,
  parameter int unsigned ID_W        = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CLIENTS-1:0]          client_req,
  output logic [NUM_CLIENTS-1:0]          client_gnt,
  input  logic [NUM_CLIENTS*DSP_IN_W-1:0] client_dsp_ins_flat,
  output logic [DSP_OUT_W-1:0]            client_dsp_outs_flat,
  output logic [DSP_IN_W-1:0]             dsp_ins_flat,
  input  logic [DSP_OUT_W-1:0]            dsp_outs_flat,
  output logic                            owner_vld,
  output logic [ID_W-1:0]                 owner_id,
  input  logic                            sample_rate_trig,
  output logic [15:0]                     util_cycles,
  output logic [15:0]                     util_peak
);

  typedef enum logic {StIdle, StOwned} state_e;

  state_e                 state_q, state_d;
  logic [ID_W-1:0]        owner_id_q, owner_id_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_CLIENTS-1:0] gnt_q, gnt_d;

  logic                     owner_req;
  logic [NUM_CLIENTS-1:0]   req_masked;
  logic [2*NUM_CLIENTS-1:0] req_dbl;
  logic [NUM_CLIENTS-1:0]   req_rot;
  logic [ID_W-1:0]          search_start;
  logic                     found;
  int unsigned              offset;
  int unsigned              winner;

  assign owner_req = |(client_req & gnt_q);

  always_comb begin
    state_d      = state_q;
    owner_id_d   = owner_id_q;
    rr_ptr_d     = rr_ptr_q;
    search_start = rr_ptr_q;
    req_masked   = client_req;
    req_dbl      = '0;
    req_rot      = '0;
    found        = 1'b0;
    offset       = 0;
    winner       = 0;

    if (!(state_q == StOwned && owner_req)) begin
      if (state_q == StOwned) begin
        // Releasing owner is excluded; the search starts just after it.
        req_masked   = client_req & ~gnt_q;
        search_start = (int'(owner_id_q) + 1 >= int'(NUM_CLIENTS)) ? '0 : owner_id_q + 1'b1;
        rr_ptr_d     = search_start;
      end
      req_dbl = {req_masked, req_masked} >> search_start;
      req_rot = req_dbl[NUM_CLIENTS-1:0];
      for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
        if (req_rot[i]) begin
          found  = 1'b1;
          offset = i;
        end
      end
      winner = int'(search_start) + offset;
      if (winner >= NUM_CLIENTS) winner = winner - NUM_CLIENTS;
      state_d    = found ? StOwned : StIdle;
      owner_id_d = found ? ID_W'(winner) : '0;
    end

    gnt_d = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      gnt_d[k] = (state_d == StOwned) && (owner_id_d == ID_W'(k));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_id_q <= '0;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_id_q <= owner_id_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
    end
  end

  assign owner_vld            = (state_q == StOwned);
  assign owner_id             = owner_id_q;
  assign client_gnt           = gnt_q;
  assign client_dsp_outs_flat = dsp_outs_flat;

  // Idle drives zeros so the DSP sees opmode 0.
  always_comb begin
    dsp_ins_flat = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (gnt_q[k]) dsp_ins_flat = client_dsp_ins_flat[k*DSP_IN_W +: DSP_IN_W];
    end
  end

`ifdef DSP_ARB_UTIL_EN
  logic [15:0] busy_q, busy_d;
  logic [15:0] util_cycles_q, util_cycles_d;
  logic [15:0] util_peak_q, util_peak_d;
  logic [16:0] busy_sum;
  logic [15:0] busy_sat;

  always_comb begin
    busy_sum      = {1'b0, busy_q} + 17'(owner_vld);
    busy_sat      = busy_sum[16] ? 16'hFFFF : busy_sum[15:0];
    busy_d        = busy_sat;
    util_cycles_d = util_cycles_q;
    util_peak_d   = util_peak_q;
    if (sample_rate_trig) begin
      busy_d        = '0;
      util_cycles_d = busy_sat;
      if (busy_sat > util_peak_q) util_peak_d = busy_sat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q        <= '0;
      util_cycles_q <= '0;
      util_peak_q   <= '0;
    end else begin
      busy_q        <= busy_d;
      util_cycles_q <= util_cycles_d;
      util_peak_q   <= util_peak_d;
    end
  end

  assign util_cycles = util_cycles_q;
  assign util_peak   = util_peak_q;
`else
  logic unused_sample_rate_trig;
  assign unused_sample_rate_trig = sample_rate_trig;
  assign util_cycles = '0;
  assign util_peak   = '0;
`endif

endmodule

// File: tb/tb_dsp_share_arb.sv
// Scoreboard bench for dsp_share_arb: driver pushes model expectations, monitor pops and compares.
module tb_dsp_share_arb;
  localparam int N    = 4;
  localparam int DIN  = 92;
  localparam int DOUT = 48;
`ifdef DSP_ARB_UTIL_EN
  localparam bit UtilEn = 1'b1;
`else
  localparam bit UtilEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      client_req = '0;
  logic [N-1:0]      client_gnt;
  logic [N*DIN-1:0]  client_dsp_ins_flat = '0;
  logic [DOUT-1:0]   client_dsp_outs_flat;
  logic [DIN-1:0]    dsp_ins_flat;
  logic [DOUT-1:0]   dsp_outs_flat = '0;
  logic              owner_vld;
  logic [2:0]        owner_id;
  logic              sample_rate_trig = 1'b0;
  logic [15:0]       util_cycles;
  logic [15:0]       util_peak;

  dsp_share_arb #(.NUM_CLIENTS(N), .DSP_IN_W(DIN), .DSP_OUT_W(DOUT), .ID_W(3)) dut (
    .clk                 (clk),
    .reset               (reset),
    .client_req          (client_req),
    .client_gnt          (client_gnt),
    .client_dsp_ins_flat (client_dsp_ins_flat),
    .client_dsp_outs_flat(client_dsp_outs_flat),
    .dsp_ins_flat        (dsp_ins_flat),
    .dsp_outs_flat       (dsp_outs_flat),
    .owner_vld           (owner_vld),
    .owner_id            (owner_id),
    .sample_rate_trig    (sample_rate_trig),
    .util_cycles         (util_cycles),
    .util_peak           (util_peak)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    gnt;
    logic            vld;
    logic [2:0]      id;
    logic [DIN-1:0]  din;
    logic [DOUT-1:0] dout;
    logic [15:0]     uc;
    logic [15:0]     up;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference model: owner index (-1 = idle), round-robin pointer, utilisation.
  int m_owner = -1;
  int m_ptr = 0;
  int m_busy = 0;
  int m_uc = 0;
  int m_up = 0;

  bit rec = 1'b0;
  int seq[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge(input logic [N-1:0] req, input logic trig);
    int excl;
    int v;
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_busy = 0; m_uc = 0; m_up = 0;
      return;
    end
    if (UtilEn) begin
      v = m_busy + ((m_owner >= 0) ? 1 : 0);
      if (v > 65535) v = 65535;
      if (trig) begin
        m_uc = v;
        if (v > m_up) m_up = v;
        m_busy = 0;
      end else begin
        m_busy = v;
      end
    end
    if (m_owner >= 0 && req[m_owner]) return;
    excl = -1;
    if (m_owner >= 0) begin
      m_ptr = (m_owner + 1) % N;
      excl = m_owner;
    end
    m_owner = -1;
    for (int i = 0; i < N; i++) begin
      int c;
      c = (m_ptr + i) % N;
      if (c != excl && req[c]) begin
        m_owner = c;
        break;
      end
    end
  endtask

  // Called at a negedge; sets inputs for the next posedge and queues the expected outcome.
  task automatic step(input logic [N-1:0] req, input logic trig);
    exp_t e;
    logic [DIN-1:0] ins [N];
    client_req = req;
    sample_rate_trig = trig;
    for (int k = 0; k < N; k++) begin
      ins[k] = {$urandom, $urandom, $urandom};
      client_dsp_ins_flat[k*DIN +: DIN] = ins[k];
    end
    dsp_outs_flat = {$urandom, $urandom};
    model_edge(req, trig);
    e.gnt  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e.vld  = (m_owner >= 0);
    e.id   = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    e.din  = (m_owner >= 0) ? ins[m_owner] : '0;
    e.dout = dsp_outs_flat;
    e.uc   = 16'(m_uc);
    e.up   = 16'(m_up);
    q.push_back(e);
    @(negedge clk);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("gnt", client_gnt, e.gnt);
      chk("owner_vld", owner_vld, e.vld);
      chk("owner_id", owner_id, e.id);
      chk("dsp_ins", dsp_ins_flat, e.din);
      chk("dsp_outs", client_dsp_outs_flat, e.dout);
      chk("util_cycles", util_cycles, e.uc);
      chk("util_peak", util_peak, e.up);
      if (rec && owner_vld && (seq.size() == 0 || seq[$] != int'(owner_id)))
        seq.push_back(int'(owner_id));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] r;
    int ten;
    int prev;
    int rot_exp[5];
    int gap;
    rot_exp = '{0, 1, 2, 3, 0};

    repeat (3) @(negedge clk);
    chk("reset_gnt", client_gnt, '0);
    chk("reset_dsp_ins", dsp_ins_flat, '0);
    reset = 1'b0;

    // Idle for 10 cycles, then all request; each owner releases after 5 cycles of tenure.
    repeat (10) step('0, 1'b0);
    rec = 1'b1;
    ten = 0;
    prev = -1;
    for (int c = 0; c < 34; c++) begin
      r = '1;
      if (m_owner >= 0 && ten >= 5) r[m_owner] = 1'b0;
      step(r, 1'b0);
      if (m_owner == prev) ten++;
      else begin
        ten = 1;
        prev = m_owner;
      end
    end
    step('0, 1'b0);
    step('0, 1'b0);
    rec = 1'b0;
    chk("rot_len_ge5", seq.size() >= 5, 1'b1);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk($sformatf("rot_%0d", i), seq[i], rot_exp[i]);

    // Owner 2 holds while client 1 waits.
    repeat (3) step(4'b0100, 1'b0);
    repeat (4) step(4'b0110, 1'b0);
    chk("hold_owner2", client_gnt, 4'b0100);
    step(4'b0010, 1'b0);
    chk("handover_1", client_gnt, 4'b0010);
    step(4'b1011, 1'b0);
    step(4'b1001, 1'b0);
    chk("ptr3_next", client_gnt, 4'b1000);
    step('0, 1'b0);

    // Owner 2 releases with no other requester.
    repeat (3) step(4'b0100, 1'b0);
    step('0, 1'b0);
    chk("idle_vld", owner_vld, 1'b0);
    chk("idle_dsp_ins", dsp_ins_flat, '0);
    step(4'b0001, 1'b0);
    chk("idle_to_0", client_gnt, 4'b0001);
    step('0, 1'b0);

    // Asynchronous reset during tenure of client 3.
    repeat (3) step(4'b1000, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_gnt", client_gnt, '0);
    chk("async_rst_vld", owner_vld, 1'b0);
    @(negedge clk);
    repeat (2) step(4'b1000, 1'b0);
    reset = 1'b0;
    step(4'b1000, 1'b0);
    chk("post_rst_gnt", client_gnt, 4'b1000);
    step('0, 1'b0);
    step('0, 1'b0);

    // Utilisation: 2000-cycle periods with 300 then 500 busy cycles.
    step('0, 1'b1);
    repeat (300) step(4'b0010, 1'b0);
    repeat (1699) step('0, 1'b0);
    step('0, 1'b1);
    chk("util_300", util_cycles, UtilEn ? 16'd300 : 16'd0);
    repeat (500) step(4'b0100, 1'b0);
    repeat (1499) step('0, 1'b0);
    step('0, 1'b1);
    chk("util_500", util_cycles, UtilEn ? 16'd500 : 16'd0);
    chk("peak_500", util_peak, UtilEn ? 16'd500 : 16'd0);

    // Random traffic with sporadic sample strobes.
    r = '0;
    gap = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(7) == 0) r[k] = ~r[k];
      gap++;
      if (gap >= 40 + int'($urandom_range(80))) begin
        gap = 0;
        step(r, 1'b1);
      end else begin
        step(r, 1'b0);
      end
    end
    step('0, 1'b0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
